wb_traffic_master: RTL and testbench

//  Parametrised Wishbone classic-cycle test master: writes DATA_COUNT generated words to a slave, reads each back and compares.

---
 rtl/wb_traffic_master_if.sv | 25 ++
 rtl/wb_traffic_master.sv | 185 ++++++++++++++++++
 tb/tb_wb_traffic_master.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_traffic_master_if.sv
// Wishbone classic-cycle bundle between the traffic master and its slave.
// Signal names and _i/_o suffixes are from the master's point of view.
interface wb_traffic_master_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
) ();
  logic                  cyc_o;
  logic                  stb_o;
  logic                  we_o;
  logic [ADDR_WIDTH-1:0] adr_o;
  logic [DATA_WIDTH-1:0] dat_o;
  logic [DATA_WIDTH-1:0] dat_i;
  logic                  ack_i;
  logic                  err_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, dat_o,
    input  dat_i, ack_i, err_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, dat_o,
    output dat_i, ack_i, err_i
  );
endinterface

// File: rtl/wb_traffic_master.sv
// Wishbone classic-cycle test master: writes DATA_COUNT generated words, reads them back and
// counts read mismatches and bus errors. Outputs are registered by the single FSM block.
// Optional ack watchdog: define WB_MASTER_TIMEOUT_EN to abort transfers after TIMEOUT_CYC
// wait cycles, counted as bus errors.
module wb_traffic_master #(
  parameter int unsigned BASE_ADDRESS = 0,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_COUNT   = 16,
  parameter int unsigned AU_IN_DATA   = 1,
  parameter int unsigned PATTERN_SEED = 'h1234,
  parameter int unsigned PATTERN_STEP = 'h1111,
  parameter int unsigned ERR_WIDTH    = 8,
  parameter int unsigned TIMEOUT_CYC  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 mode_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [ERR_WIDTH-1:0] mism_cnt_o,
  output logic [ERR_WIDTH-1:0] berr_cnt_o,
  wb_traffic_master_if.master  wb
);

  localparam int unsigned IdxW = $clog2(DATA_COUNT);

  if (DATA_COUNT < 2 || DATA_COUNT > 65536) begin : g_bad_count
    $error("DATA_COUNT must be in 2..65536");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [2:0] {StIdle, StWrReq, StWrWait, StRdReq, StRdWait} state_e;

  state_e                 state_q;
  logic [IdxW-1:0]        idx_q;
  logic                   mode_q, start_q, busy_q, done_q;
  logic                   cyc_q, stb_q, we_q;
  logic [ADDR_WIDTH-1:0]  adr_q;
  logic [DATA_WIDTH-1:0]  dat_q;
  logic [ERR_WIDTH-1:0]   mism_q, berr_q;

  logic [ADDR_WIDTH-1:0]  adr_cur;
  logic [DATA_WIDTH-1:0]  pat_cur;
  logic                   last, start_fall, timeout, bus_err, term;

  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Address, pattern and termination decode for the current word index.
  always_comb begin
    adr_cur    = ADDR_WIDTH'(BASE_ADDRESS + 32'(idx_q) * AU_IN_DATA);
    pat_cur    = DATA_WIDTH'(PATTERN_SEED) + DATA_WIDTH'(idx_q) * DATA_WIDTH'(PATTERN_STEP);
    last       = (idx_q == IdxW'(DATA_COUNT - 1));
    start_fall = start_q & ~start_i;
    bus_err    = wb.err_i | timeout;
    term       = wb.ack_i | bus_err;
  end

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);
  logic [ToW-1:0] to_cnt_q;
  logic           in_wait;

  assign in_wait = (state_q == StWrWait) || (state_q == StRdWait);
  // Abort on the TIMEOUT_CYC-th wait cycle that sees neither ack nor err.
  assign timeout = in_wait && !wb.ack_i && !wb.err_i && (to_cnt_q == ToW'(TIMEOUT_CYC - 1));

  // Watchdog: cleared by each request, advances every wait cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else if (state_q == StWrReq || state_q == StRdReq) begin
      to_cnt_q <= '0;
    end else if (in_wait) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Run sequencer with registered bus and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      mism_q  <= '0;
      berr_q  <= '0;
    end else begin
      start_q <= start_i;
      unique case (state_q)
        StIdle: begin
          if (start_fall) begin
            mode_q  <= mode_i;
            idx_q   <= '0;
            mism_q  <= '0;
            berr_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StWrReq;
          end
        end
        StWrReq: begin
          cyc_q   <= 1'b1;
          stb_q   <= 1'b1;
          we_q    <= 1'b1;
          adr_q   <= adr_cur;
          dat_q   <= pat_cur;
          state_q <= StWrWait;
        end
        StRdReq: begin
          cyc_q   <= 1'b1;
          stb_q   <= 1'b1;
          we_q    <= 1'b0;
          adr_q   <= adr_cur;
          state_q <= StRdWait;
        end
        StWrWait: begin
          if (term) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            if (bus_err) berr_q <= sat_inc(berr_q);
            if (!mode_q) begin
              state_q <= StRdReq;
            end else if (last) begin
              idx_q   <= '0;
              state_q <= StRdReq;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= StWrReq;
            end
          end
        end
        StRdWait: begin
          if (term) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            // An err termination wins over ack; its read data is not trusted.
            if (bus_err) begin
              berr_q <= sat_inc(berr_q);
            end else if (wb.dat_i != pat_cur) begin
              mism_q <= sat_inc(mism_q);
            end
            if (last) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= mode_q ? StRdReq : StWrReq;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wb.cyc_o   = cyc_q;
  assign wb.stb_o   = stb_q;
  assign wb.we_o    = we_q;
  assign wb.adr_o   = adr_q;
  assign wb.dat_o   = dat_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign mism_cnt_o = mism_q;
  assign berr_cnt_o = berr_q;

endmodule

// File: tb/tb_wb_traffic_master.sv
// Directed bench for wb_traffic_master: memory slave with wait states and fault injection,
// a transfer logger, and per-run comparison of the logged bus traffic and status counters.
module tb_wb_traffic_master;
  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 16;
  localparam int unsigned DC   = 16;
  localparam int unsigned AU   = 4;
  localparam int unsigned BASE = 'h100;
  localparam int unsigned TO   = 8;
  localparam int unsigned EW   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          mode_i = 1'b0;
  logic          busy_o, done_o;
  logic [EW-1:0] mism_cnt_o, berr_cnt_o;

  wb_traffic_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) wb ();

  wb_traffic_master #(
    .BASE_ADDRESS(BASE),
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .DATA_COUNT  (DC),
    .AU_IN_DATA  (AU),
    .ERR_WIDTH   (EW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .mode_i    (mode_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .mism_cnt_o(mism_cnt_o),
    .berr_cnt_o(berr_cnt_o),
    .wb        (wb)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pattern(input int unsigned i);
    return DW'(32'h1234 + i * 32'h1111);
  endfunction

  function automatic logic [AW-1:0] exp_adr(input int unsigned i);
    return AW'(BASE + i * AU);
  endfunction

  // ---------------- slave model ----------------
  int            ws = 0;
  int            ws_cnt = 0;
  logic          err_wr_en = 1'b0, err_rd_en = 1'b0, bad_rd_en = 1'b0, hang_en = 1'b0;
  logic [AW-1:0] err_wr_adr = '0, err_rd_adr = '0, bad_rd_adr = '0, hang_adr = '0;
  logic          mem_clr = 1'b0, log_clr = 1'b0;
  logic [DW-1:0] mem [0:255];
  logic          hit, hang_now, corrupt;

  assign hit      = wb.cyc_o & wb.stb_o & (ws_cnt == ws);
  assign hang_now = hang_en & wb.we_o & (wb.adr_o == hang_adr);
  assign corrupt  = ~wb.we_o & ((bad_rd_en & (wb.adr_o == bad_rd_adr)) |
                                (err_rd_en & (wb.adr_o == err_rd_adr)));
  assign wb.ack_i = hit & ~hang_now;
  assign wb.err_i = hit & ((err_wr_en & wb.we_o & (wb.adr_o == err_wr_adr)) |
                           (err_rd_en & ~wb.we_o & (wb.adr_o == err_rd_adr)));
  assign wb.dat_i = mem[wb.adr_o[7:0]] ^ (corrupt ? DW'('h00F0) : DW'(0));

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (wb.ack_i && !wb.err_i && wb.we_o) begin
      mem[wb.adr_o[7:0]] <= wb.dat_o;
    end
    if (!(wb.cyc_o && wb.stb_o) || wb.ack_i || wb.err_i) ws_cnt <= 0;
    else ws_cnt <= ws_cnt + 1;
  end

  // ---------------- transfer logger (mid-cycle sampling) ----------------
  logic          lg_we  [0:63];
  logic [AW-1:0] lg_adr [0:63];
  logic [DW-1:0] lg_dat [0:63];
  int            lg_n   [0:63];
  int            n_log = 0;
  logic          open_q = 1'b0;
  logic          cur_we = 1'b0;
  logic [AW-1:0] cur_adr = '0;
  logic [DW-1:0] cur_dat = '0;
  int            cur_n = 0;
  int            gap = 0;
  int            gap_bad = 0;

  always @(negedge clk) begin
    if (rst || log_clr) begin
      open_q  <= 1'b0;
      n_log   <= 0;
      gap     <= 0;
      gap_bad <= 0;
      cur_n   <= 0;
    end else if (wb.cyc_o) begin
      if (!open_q) begin
        open_q  <= 1'b1;
        cur_we  <= wb.we_o;
        cur_adr <= wb.adr_o;
        cur_dat <= wb.dat_o;
        cur_n   <= 1;
        if (gap != 1) gap_bad <= gap_bad + 1;
        gap <= 0;
      end else begin
        cur_n <= cur_n + 1;
      end
    end else begin
      if (open_q) begin
        open_q <= 1'b0;
        if (n_log < 64) begin
          lg_we[n_log]  <= cur_we;
          lg_adr[n_log] <= cur_adr;
          lg_dat[n_log] <= cur_dat;
          lg_n[n_log]   <= cur_n;
        end
        n_log <= n_log + 1;
      end
      if (busy_o) gap <= gap + 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prep();
    mem_clr = 1'b1;
    log_clr = 1'b1;
    tick();
    mem_clr = 1'b0;
    log_clr = 1'b0;
  endtask

  task automatic run_start(input logic m);
    mode_i  = m;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    check_val("start_busy", busy_o, 1);
    check_val("start_done", done_o, 0);
    check_val("start_mism", mism_cnt_o, 0);
    check_val("start_berr", berr_cnt_o, 0);
  endtask

  task automatic wait_done(input int limit);
    for (int k = 0; k < limit && !done_o; k++) tick();
    check_val("run_done", done_o, 1);
    check_val("run_busy", busy_o, 0);
    tick();
    tick();
  endtask

  task automatic check_run(input int m, input int ncyc, input int hang_i);
    int n;
    n = (n_log < 2 * DC) ? n_log : 2 * DC;
    check_val($sformatf("m%0d_nxfer", m), n_log, 2 * DC);
    check_val($sformatf("m%0d_gap", m), gap_bad, 0);
    for (int k = 0; k < n; k++) begin
      logic        we;
      int unsigned i;
      int          exp_n;
      we    = (m == 0) ? (k % 2 == 0) : (k < DC);
      i     = (m == 0) ? k / 2 : k % DC;
      exp_n = (we && int'(i) == hang_i) ? TO : ncyc;
      check_val($sformatf("m%0d_k%0d_we", m, k), lg_we[k], we);
      check_val($sformatf("m%0d_k%0d_adr", m, k), lg_adr[k], exp_adr(i));
      check_val($sformatf("m%0d_k%0d_cyc", m, k), lg_n[k], exp_n);
      if (we) check_val($sformatf("m%0d_k%0d_dat", m, k), lg_dat[k], pattern(i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state while reset is held.
    repeat (3) tick();
    check_val("rst_busy", busy_o, 0);
    check_val("rst_done", done_o, 0);
    check_val("rst_cyc", wb.cyc_o, 0);
    check_val("rst_stb", wb.stb_o, 0);
    check_val("rst_we", wb.we_o, 0);
    check_val("rst_adr", wb.adr_o, 0);
    check_val("rst_dat", wb.dat_o, 0);
    check_val("rst_mism", mism_cnt_o, 0);
    check_val("rst_berr", berr_cnt_o, 0);
    rst = 1'b0;
    repeat (3) tick();
    check_val("idle_busy", busy_o, 0);

    // Interleaved, zero wait.
    ws = 0;
    prep();
    run_start(1'b0);
    wait_done(1000);
    check_run(0, 1, -1);
    check_val("a_mism", mism_cnt_o, 0);
    check_val("a_berr", berr_cnt_o, 0);
    check_val("a_adr_hold", wb.adr_o, exp_adr(DC - 1));
    check_val("a_dat_hold", wb.dat_o, pattern(DC - 1));
    check_val("a_cyc_idle", wb.cyc_o, 0);

    // Block mode, zero wait.
    prep();
    run_start(1'b1);
    wait_done(1000);
    check_run(1, 1, -1);
    check_val("b_mism", mism_cnt_o, 0);
    check_val("b_berr", berr_cnt_o, 0);

    // Corrupt read of 5, err+ack on write of 9 (not stored), err+ack with bad data on read 12.
    bad_rd_en = 1'b1; bad_rd_adr = exp_adr(5);
    err_wr_en = 1'b1; err_wr_adr = exp_adr(9);
    err_rd_en = 1'b1; err_rd_adr = exp_adr(12);
    prep();
    run_start(1'b0);
    wait_done(1000);
    check_run(0, 1, -1);
    check_val("c_mism", mism_cnt_o, 2);
    check_val("c_berr", berr_cnt_o, 2);
    repeat (5) tick();
    check_val("c_mism_hold", mism_cnt_o, 2);
    check_val("c_berr_hold", berr_cnt_o, 2);
    bad_rd_en = 1'b0;
    err_wr_en = 1'b0;
    err_rd_en = 1'b0;

    // Three wait states, second start pulse while busy must be ignored.
    ws = 3;
    prep();
    run_start(1'b1);
    repeat (20) tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    check_val("d_busy_mid", busy_o, 1);
    wait_done(2000);
    repeat (20) tick();
    check_val("d_still_idle", busy_o, 0);
    check_val("d_done_kept", done_o, 1);
    check_run(1, 4, -1);
    check_val("d_mism", mism_cnt_o, 0);

    // Reset during a read wait, then a clean run.
    ws = 2;
    prep();
    run_start(1'b0);
    for (int k = 0; k < 500; k++) begin
      if (n_log >= 5 && wb.cyc_o && !wb.we_o) break;
      tick();
    end
    check_val("e_in_rdwait", wb.cyc_o & ~wb.we_o, 1);
    #2;
    rst = 1'b1;
    #1;
    check_val("e_async_cyc", wb.cyc_o, 0);
    check_val("e_async_stb", wb.stb_o, 0);
    check_val("e_async_busy", busy_o, 0);
    check_val("e_async_done", done_o, 0);
    tick();
    rst = 1'b0;
    tick();
    check_val("e_adr_cleared", wb.adr_o, 0);
    ws = 0;
    prep();
    run_start(1'b0);
    wait_done(1000);
    check_run(0, 1, -1);
    check_val("e_mism", mism_cnt_o, 0);
    check_val("e_berr", berr_cnt_o, 0);

`ifdef WB_MASTER_TIMEOUT_EN
    // Slave never answers the write of index 3.
    ws = 1;
    hang_en = 1'b1;
    hang_adr = exp_adr(3);
    prep();
    run_start(1'b0);
    wait_done(2000);
    check_run(0, 2, 3);
    check_val("f_berr", berr_cnt_o, 1);
    check_val("f_mism", mism_cnt_o, 1);
    hang_en = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
